// File: rtl/ann_defs_pkg.sv
// rtl/ann_defs_pkg.sv - shared neuron constants, state encoding and saturation bounds
`ifndef ANN_DEFS_SAT_BOUNDS
`define ANN_DEFS_SAT_BOUNDS
`define ANN_SAT_HI(WID) ((1 <<< ((WID) - 1)) - 1)
`define ANN_SAT_LO(WID) (-(1 <<< ((WID) - 1)))
`endif

package ann_defs;
  localparam int DEF_N        = 4;
  localparam int DEF_W        = 4;
  localparam int DEF_LR_SHIFT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR  = 2'd1,
    ST_UPD  = 2'd2,
    ST_DONE = 2'd3
  } state_e;
endpackage

// File: rtl/weight_updater_sat_mac_step.sv
// rtl/weight_updater_sat_mac_step.sv - one saturating weight step: w + ((err*x) >>> LR_SHIFT)
module sat_mac_step #(
  parameter int W        = 4,
  parameter int LR_SHIFT = 1
) (
  input  logic signed [W-1:0] w_i,
  input  logic signed [W-1:0] err_i,
  input  logic signed [W-1:0] x_i,
  output logic signed [W-1:0] w_o
);
  localparam logic signed [2*W:0] SUM_HI = (2*W+1)'(`ANN_SAT_HI(W));
  localparam logic signed [2*W:0] SUM_LO = (2*W+1)'(`ANN_SAT_LO(W));

  logic signed [2*W-1:0] prod;
  logic signed [2*W-1:0] delta;
  logic signed [2*W:0]   sum;

  assign prod  = err_i * x_i;
  assign delta = prod >>> LR_SHIFT;
  // One guard bit above the product width so the add itself can never wrap.
  assign sum   = {{(W+1){w_i[W-1]}}, w_i} + {delta[2*W-1], delta};

  always_comb begin
    w_o = sum[W-1:0];
    if (sum > SUM_HI) w_o = SUM_HI[W-1:0];
    else if (sum < SUM_LO) w_o = SUM_LO[W-1:0];
  end
endmodule

// File: rtl/weight_updater.sv
// rtl/weight_updater.sv - sequential error-driven weight update with owned weight file
module weight_updater
  import ann_defs::*;
#(
  parameter int N        = DEF_N,
  parameter int W        = DEF_W,
  parameter int LR_SHIFT = DEF_LR_SHIFT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_en,
  input  logic [N*W-1:0] w_load_flat,
  input  logic           start,
  input  logic [W-1:0]   target,
  input  logic [W-1:0]   y,
  input  logic [N*W-1:0] x_flat,
  output logic [N*W-1:0] w_flat,
  output logic [W-1:0]   err_out,
  output logic           busy,
  output logic           done
);
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [W:0] ERR_HI = (W+1)'(`ANN_SAT_HI(W));
  localparam logic signed [W:0] ERR_LO = (W+1)'(`ANN_SAT_LO(W));
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [N*W-1:0]  w_q, w_d;
  logic [N*W-1:0]  x_q, x_d;
  logic [W-1:0]    tgt_q, tgt_d;
  logic [W-1:0]    yv_q, yv_d;
  logic [W-1:0]    err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic signed [W:0] raw;
  logic [W-1:0]      err_sat;
  logic [W-1:0]      w_cur, x_cur, w_next;

  assign raw     = $signed({tgt_q[W-1], tgt_q}) - $signed({yv_q[W-1], yv_q});
  assign err_sat = (raw > ERR_HI) ? ERR_HI[W-1:0] :
                   (raw < ERR_LO) ? ERR_LO[W-1:0] : raw[W-1:0];
  assign w_cur   = w_q[int'(idx_q)*W +: W];
  assign x_cur   = x_q[int'(idx_q)*W +: W];

  sat_mac_step #(.W(W), .LR_SHIFT(LR_SHIFT)) u_step (
    .w_i  (w_cur),
    .err_i(err_q),
    .x_i  (x_cur),
    .w_o  (w_next)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    w_d     = w_q;
    x_d     = x_q;
    tgt_d   = tgt_q;
    yv_d    = yv_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load_en) begin
          w_d = w_load_flat;
        end else if (start) begin
          tgt_d   = target;
          yv_d    = y;
          x_d     = x_flat;
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        err_d   = err_sat;
        idx_d   = '0;
        state_d = ST_UPD;
      end
      ST_UPD: begin
        w_d[int'(idx_q)*W +: W] = w_next;
        if (idx_q == IDX_LAST) state_d = ST_DONE;
        else idx_d = idx_q + IDXW'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Flags are registered from the next state so they line up with it.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      w_q     <= '0;
      x_q     <= '0;
      tgt_q   <= '0;
      yv_q    <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
      x_q     <= x_d;
      tgt_q   <= tgt_d;
      yv_q    <= yv_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign w_flat  = w_q;
  assign err_out = err_q;
  assign busy    = busy_q;
  assign done    = done_q;
endmodule

// File: doc/weight_updater.md
Name: weight_updater

Overview:
- Backward-direction counterpart of the neuron's forward summing stage.
- The forward path adds weighted inputs to produce output y. This block subtracts y from the target to get an error, then walks the neuron's N weights sequentially, applying w_i += (err * x_i) >>> LR_SHIFT with saturation.
- Owns the neuron's weight register file and exports it flat to the forward multiply/sum path.

Parameters:
- N, 4, number of neuron inputs/weights.
- W, 4, bit width of x, y, target, err and each weight; all are signed two's complement.
- LR_SHIFT, 1, learning-rate shift; the product is arithmetically shifted right by this amount.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- load_en  input  1  load w_load_flat into the weight file; honoured in IDLE only.
- w_load_flat  input  N*W  weights to load; weight i is [i*W +: W].
- start  input  1  single-cycle request to run one update; honoured in IDLE only.
- target  input  W  desired output; sampled on accepted start.
- y  input  W  actual forward output; sampled on accepted start.
- x_flat  input  N*W  neuron inputs; x_i is [i*W +: W]; sampled on accepted start.
- w_flat  output  N*W  current weights, registered.
- err_out  output  W  saturated error from the last run, registered.
- busy  output  1  high while an update is in progress.
- done  output  1  one-cycle pulse when an update completes.

Behaviour:
- Reset, synchronous: all weights 0, err_out 0, busy 0, done 0, state IDLE, index 0. Reset overrides every other input in the same cycle. Reset asserted mid-update aborts the run with no partial-commit guarantee; after reset all weights are 0.
- States: IDLE, ERR, UPD, DONE.
- IDLE:
  - load_en=1: w_flat <= w_load_flat on the next edge; any start in the same cycle is ignored (load wins).
  - Else start=1: capture target, y and x_flat into internal registers; go to ERR; busy <= 1.
- ERR (1 cycle):
  - raw = target - y, computed at W+1 bits, signed.
  - err = raw saturated to [-2^(W-1), 2^(W-1)-1]; err_out <= err.
  - idx <= 0; go to UPD.
- UPD (N cycles, one weight per cycle, idx = 0..N-1):
  - p = err * x_idx, full 2W-bit signed product.
  - d = p >>> LR_SHIFT, arithmetic shift (floors toward -inf).
  - s = w_idx + d, computed at 2W+1 bits, then saturated to W bits; w_idx <= s.
  - After idx = N-1, go to DONE.
- DONE (1 cycle): done = 1, busy = 0 on the following edge, return to IDLE.
- busy is high from the cycle after start through the DONE cycle inclusive.
- Latency: start accepted at edge T0; done is high in the cycle after edge T0+N+1, i.e. N+2 cycles after start (6 for N=4).
- start or load_en while busy is ignored, with no queuing.
- Captured operands are frozen: changes to target, y or x_flat during busy have no effect.
- w_flat reflects each per-weight write as it occurs, so a mid-run read shows a mix of old and new weights. Consumers sample w_flat only when busy=0.

Decomposition:
- Shared include/package ann_defs holds:
  - default W, N and LR_SHIFT constants;
  - the state encoding constants (IDLE=0, ERR=1, UPD=2, DONE=3);
  - the saturation bounds macros.
- One combinational sub-module is natural: sat_mac_step (inputs w, err, x; parameters W and LR_SHIFT; output is the saturated new weight). The FSM, index counter, operand capture and weight file stay in weight_updater.

Test Plan:
- Reset: assert rst for 2 cycles -> w_flat=0, err_out=0, busy=0, done=0.
- Basic update: load {1,2,3,4} (w0..w3); start with target=5, y=3, x={1,1,1,1} -> err_out=2, w_flat={2,3,4,5}; done pulses exactly 6 cycles after start; busy high for cycles 1..6.
- Saturation:
  - Positive: w0=7, target=7, y=-8, x0=7 -> err saturates to 7; d=24; w0=7.
  - Negative: w0=-8, target=-8, y=7, x0=7 -> err=-8; d=-28; w0=-8.
- Arithmetic shift floor: w=0, target=2, y=3, x0=1 -> err=-1; d=-1; w0=4'hF. Check x_i=0 leaves w_i unchanged.
- Ignored requests: pulse start and load_en while busy -> no effect, single done. start together with load_en in IDLE -> load applied, no run, busy stays 0.
- Reset mid-update: assert rst 3 cycles after start -> next cycle all weights 0, busy=0, no done. A fresh start afterwards completes normally.
